complex_addsub_arbiter: RTL



---
 rtl/complex_addsub_arbiter_pkg.sv | 23 ++
 rtl/add_sub.sv | 28 ++
 rtl/complex_addsub_arbiter_rr_arbiter.sv | 45 ++++
 rtl/complex_addsub_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/complex_addsub_arbiter_pkg.sv
// Shared types and helpers for the complex add/sub arbiter slice.
// Holds the controller state encoding and the per-component overflow rule.
package complex_addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Signed overflow from sign bits only, so it is independent of W.
  function automatic logic comp_ovf(input logic sa, input logic sb,
                                    input logic sr, input logic sub);
    logic ovf;
    if (sub) begin
      ovf = (sa != sb) && (sr != sa);
    end else begin
      ovf = (sa == sb) && (sr != sa);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational complex adder/subtractor; Re in the upper W bits, Im in the lower.
// Each component wraps modulo 2^W independently.
module add_sub #(
  parameter int W = 8
) (
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           mode,
  output logic [2*W-1:0] out
);

  logic [W-1:0] re_s;
  logic [W-1:0] im_s;

  // mode = 1 selects A - B, otherwise A + B
  always_comb begin
    if (mode) begin
      re_s = a[2*W-1:W] - b[2*W-1:W];
      im_s = a[W-1:0]   - b[W-1:0];
    end else begin
      re_s = a[2*W-1:W] + b[2*W-1:W];
      im_s = a[W-1:0]   + b[W-1:0];
    end
  end

  assign out = {re_s, im_s};

endmodule

// File: rtl/complex_addsub_arbiter_rr_arbiter.sv
// Round-robin request picker: first set bit searching from ptr+1 upward, wrapping.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic           found_s;
  logic [IDW-1:0] cand_s;
  int             pos_s;

  // Walk the NREQ positions after ptr; the first requester seen wins
  always_comb begin
    grant   = {NREQ{1'b0}};
    idx     = {IDW{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDW{1'b0}};
    pos_s   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pos_s = int'(ptr) + i;
      if (pos_s >= NREQ) begin
        pos_s = pos_s - NREQ;
      end else begin
        pos_s = pos_s;
      end
      cand_s = IDW'(pos_s);
      if (!found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/complex_addsub_arbiter.sv
// Shares one complex add/sub unit among NREQ requesters with round-robin grants.
// IDLE grants and latches operands, EXEC registers the result, RESP holds it until accepted.
module complex_addsub_arbiter
  import complex_addsub_arbiter_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*2*W-1:0]  req_a,
  input  logic [NREQ*2*W-1:0]  req_b,
  input  logic [NREQ-1:0]      req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*W-1:0]       rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ovf,
  output logic                 busy
);

  state_t         state_r;
  logic [IDW-1:0] ptr_r;
  logic [2*W-1:0] op_a_r;
  logic [2*W-1:0] op_b_r;
  logic           op_mode_r;
  logic [IDW-1:0] op_id_r;
  logic           rsp_valid_r;
  logic [2*W-1:0] rsp_data_r;
  logic [IDW-1:0] rsp_id_r;
  logic           rsp_ovf_r;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic            any_s;
  logic [2*W-1:0]  sel_a_s;
  logic [2*W-1:0]  sel_b_s;
  logic            sel_mode_s;
  logic [2*W-1:0]  sum_s;
  logic            ovf_re_s;
  logic            ovf_im_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (grant_idx_s),
    .any   (any_s)
  );

  // One-hot operand mux driven by the arbiter grant
  always_comb begin
    sel_a_s    = {2*W{1'b0}};
    sel_b_s    = {2*W{1'b0}};
    sel_mode_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        sel_a_s    = req_a[i*2*W +: 2*W];
        sel_b_s    = req_b[i*2*W +: 2*W];
        sel_mode_s = req_mode[i];
      end else begin
        sel_mode_s = sel_mode_s;
      end
    end
  end

  add_sub #(.W(W)) u_add_sub (
    .a    (op_a_r),
    .b    (op_b_r),
    .mode (op_mode_r),
    .out  (sum_s)
  );

  assign ovf_re_s = comp_ovf(op_a_r[2*W-1], op_b_r[2*W-1], sum_s[2*W-1], op_mode_r);
  assign ovf_im_s = comp_ovf(op_a_r[W-1],   op_b_r[W-1],   sum_s[W-1],   op_mode_r);

  // Controller: grant/latch, execute, then hold the response until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= IDW'(NREQ - 1);
      op_a_r      <= {2*W{1'b0}};
      op_b_r      <= {2*W{1'b0}};
      op_mode_r   <= 1'b0;
      op_id_r     <= {IDW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {2*W{1'b0}};
      rsp_id_r    <= {IDW{1'b0}};
      rsp_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            op_a_r    <= sel_a_s;
            op_b_r    <= sel_b_s;
            op_mode_r <= sel_mode_s;
            op_id_r   <= grant_idx_s;
            ptr_r     <= grant_idx_s;
            state_r   <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_data_r  <= sum_s;
          rsp_ovf_r   <= ovf_re_s | ovf_im_s;
          rsp_id_r    <= op_id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_r == ST_IDLE) ? grant_s : {NREQ{1'b0}};
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_ovf   = rsp_ovf_r;

endmodule
